uart_tx_engine: RTL and testbench

- Downstream consumer of the 8-deep byte TX FIFO in the APB UART peripheral.
- Pops one byte at a time when the FIFO is non-empty and transmission is enabled.
- Serializes each byte onto the TX pin as 8N1 (start bit, 8 data bits LSB first, stop bit(s)), timed by a programmable baud divisor.
- Reports busy status and a per-frame done pulse to the APB register block.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_baud_tick.sv | 23 ++
 rtl/uart_tx_engine.sv | 126 ++++++++++++
 tb/tb_uart_tx_engine.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and constants for the UART transmit path
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int UART_DEFAULT_DIV = 16;
  localparam int UART_DATA_BITS = 8;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer that ticks on the last cycle of each div-cycle period
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  // tick at div-1, then wrap; any clear or idle period restarts the count
  always_comb begin
    tick = en && (cnt_q == div - DIV_W'(1));
    cnt_d = (clr || tick || !en) ? '0 : cnt_q + DIV_W'(1);
  end
  // counter register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx_engine.sv
// uart_tx_engine: pops FIFO bytes and serializes them as 8N1 frames; UART_TX_PARITY_EN adds a parity bit
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int STOP_BITS = 1,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             tx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_data,
`ifdef UART_TX_PARITY_EN
  input  logic             parity_en,
  input  logic             parity_odd,
`endif
  output logic             fifo_r_enable,
  output logic             tx,
  output logic             busy,
  output logic             tx_done
);
  state_t state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic tick;
`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d, par_val_q, par_val_d;
`endif
  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk  (clk),
    .n_rst(n_rst),
    .clr  (state_d != state_q),
    .en   (state_q != IDLE),
    .div  (div_q),
    .tick (tick)
  );
  assign busy = (state_q != IDLE);
  // frame sequencing: pop and latch in IDLE, then start, data LSB first, optional parity, stop
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    div_d = div_q;
    bit_d = bit_q;
    fifo_r_enable = 1'b0;
    tx = 1'b1;
    tx_done = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d = par_en_q;
    par_val_d = par_val_q;
`endif
    case (state_q)
      IDLE: if (tx_en && !fifo_empty) begin
        fifo_r_enable = 1'b1;
        shift_d = fifo_data;
        div_d = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
        bit_d = '0;
        state_d = START;
`ifdef UART_TX_PARITY_EN
        par_en_d = parity_en;
        par_val_d = (^fifo_data) ^ parity_odd;
`endif
      end
      START: begin
        tx = 1'b0;
        state_d = tick ? DATA : START;
      end
      DATA: begin
        tx = shift_q[0];
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'(UART_DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx = par_val_q;
        state_d = tick ? STOP : PARITY;
      end
`endif
      STOP: if (tick) begin
        if (bit_q == 3'(STOP_BITS - 1)) begin
          tx_done = 1'b1;
          bit_d = '0;
          state_d = IDLE;
        end else bit_d = bit_q + 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // state, shift register, latched divisor and stop-bit count
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      div_q <= '0;
      bit_q <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      div_q <= div_d;
      bit_q <= bit_d;
    end
  end
`ifdef UART_TX_PARITY_EN
  // parity settings captured at the pop so mid-frame changes wait for the next byte
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      par_en_q <= 1'b0;
      par_val_q <= 1'b0;
    end else begin
      par_en_q <= par_en_d;
      par_val_q <= par_val_d;
    end
  end
`endif
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: randomized bench with a queue-based frame model checked every cycle
module tb_uart_tx_engine;
  localparam int SB = 1;
  logic clk = 1'b0;
  logic n_rst, tx_en, fifo_empty, fifo_r_enable, tx, busy, tx_done;
  logic [15:0] baud_div;
  logic [7:0] fifo_data;
`ifdef UART_TX_PARITY_EN
  logic parity_en = 1'b0, parity_odd = 1'b0;
`endif
  int checks = 0, failures = 0, cyc = 0, busy_cnt = 0;
  logic [7:0] fq[$];
  logic [1:0] exp_q[$];
  int pops[$], dones[$];
  bit txlog[0:8191];
  logic [9:0] lit = 10'b1101001010;

  uart_tx_engine #(.STOP_BITS(SB), .DIV_W(16)) dut (
    .clk(clk), .n_rst(n_rst), .tx_en(tx_en), .baud_div(baud_div),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data),
`ifdef UART_TX_PARITY_EN
    .parity_en(parity_en), .parity_odd(parity_odd),
`endif
    .fifo_r_enable(fifo_r_enable), .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  function automatic void refresh();
    fifo_empty = (fq.size() == 0);
    fifo_data = fifo_empty ? 8'h3C : fq[0];
  endfunction

  task automatic chk(string n, logic a, logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", n, cyc, a, e);
    end
  endtask

  task automatic pin(string n, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", n, a, e);
    end
  endtask

  // whole frame as a per-cycle list of {tx, tx_done}
  function automatic void build_frame(logic [7:0] b);
    int d = (baud_div < 16'd2) ? 2 : int'(baud_div);
    for (int i = 0; i < d; i++) exp_q.push_back(2'b00);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < d; i++) exp_q.push_back({b[k], 1'b0});
`ifdef UART_TX_PARITY_EN
    if (parity_en)
      for (int i = 0; i < d; i++) exp_q.push_back({(^b) ^ parity_odd, 1'b0});
`endif
    for (int i = 0; i < SB * d; i++) exp_q.push_back({1'b1, i == SB * d - 1});
  endfunction

  task automatic step();
    logic e_tx, e_busy, e_done, e_pop, pop_seen;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      e_pop = tx_en && (fq.size() > 0);
      if (e_pop) build_frame(fq[0]);
    end else begin
      {e_tx, e_done} = exp_q.pop_front();
      e_busy = 1'b1; e_pop = 1'b0;
    end
    chk("tx", tx, e_tx);
    chk("busy", busy, e_busy);
    chk("tx_done", tx_done, e_done);
    chk("fifo_r_enable", fifo_r_enable, e_pop);
    pop_seen = fifo_r_enable;
    if (pop_seen) pops.push_back(cyc);
    if (tx_done) dones.push_back(cyc);
    busy_cnt += int'(busy);
    if (cyc < 8192) txlog[cyc] = tx;
    @(posedge clk);
    #1;
    cyc++;
    if (pop_seen && fq.size() > 0) void'(fq.pop_front());
    refresh();
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic clear_log();
    pops.delete();
    dones.delete();
    busy_cnt = 0;
  endtask

  initial begin
    n_rst = 1'b0; tx_en = 1'b0; baud_div = 16'd4;
    refresh();
    #2;
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_pop", fifo_r_enable, 1'b0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // single 0xA5 frame at divisor 4
    tx_en = 1'b1; fq.push_back(8'hA5); refresh(); clear_log();
    run(50);
    pin("single_pops", pops.size(), 1);
    pin("single_len", (pops.size() > 0 && dones.size() > 0) ? dones[0] - pops[0] : -1, 40);
    pin("single_busy", busy_cnt, 40);
    if (pops.size() > 0)
      for (int k = 0; k < 10; k++) pin("single_bit", int'(txlog[pops[0] + 3 + 4 * k]), int'(lit[k]));

    // back-to-back 0x00, 0xFF at divisor 2
    baud_div = 16'd2; fq.push_back(8'h00); fq.push_back(8'hFF); refresh(); clear_log();
    run(50);
    pin("b2b_pops", pops.size(), 2);
    pin("b2b_gap", pops.size() > 1 ? pops[1] - pops[0] : -1, 21);
    pin("b2b_idle", (pops.size() > 1 && dones.size() > 0) ? pops[1] - dones[0] : -1, 1);

    // empty FIFO, then disabled with data waiting
    clear_log();
    run(100);
    tx_en = 1'b0; fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); refresh();
    run(100);
    pin("idle_pops", pops.size(), 0);
    pin("idle_busy", busy_cnt, 0);
    fq.delete(); refresh();

    // divisor change mid-frame applies to the next frame only
    tx_en = 1'b1; baud_div = 16'd4; fq.push_back(8'h5A); fq.push_back(8'hC3); refresh(); clear_log();
    run(11);
    baud_div = 16'd8;
    run(140);
    pin("div_len0", (pops.size() > 0 && dones.size() > 0) ? dones[0] - pops[0] : -1, 40);
    pin("div_len1", (pops.size() > 1 && dones.size() > 1) ? dones[1] - pops[1] : -1, 80);

    // divisor 0 clamps to 2
    baud_div = 16'd0; fq.push_back(8'h81); refresh(); clear_log();
    run(30);
    pin("clamp_len", (pops.size() > 0 && dones.size() > 0) ? dones[0] - pops[0] : -1, 20);

    // reset during data bit 3, then a clean frame
    baud_div = 16'd4; fq.push_back(8'h96); fq.push_back(8'h3E); refresh(); clear_log();
    run(19);
    n_rst = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    exp_q.delete();
    #1;
    n_rst = 1'b1;
    clear_log();
    run(60);
    pin("post_rst_pops", pops.size(), 1);
    pin("post_rst_len", (pops.size() > 0 && dones.size() > 0) ? dones[0] - pops[0] : -1, 40);

`ifdef UART_TX_PARITY_EN
    // 0x07 has odd weight: even parity bit 1, odd parity bit 0
    parity_en = 1'b1;
    for (int o = 0; o < 2; o++) begin
      parity_odd = o[0]; fq.push_back(8'h07); refresh(); clear_log();
      run(50);
      pin("par_len", (pops.size() > 0 && dones.size() > 0) ? dones[0] - pops[0] : -1, 44);
      pin("par_bit", pops.size() > 0 ? int'(txlog[pops[0] + 39]) : -1, 1 - o);
    end
    parity_en = 1'b0; parity_odd = 1'b0;
`endif

    // randomized traffic, enable and divisor
    repeat (400) begin
      if ($urandom_range(0, 3) == 0 && fq.size() < 4) fq.push_back(8'($urandom));
      tx_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) baud_div = 16'($urandom_range(0, 5));
`ifdef UART_TX_PARITY_EN
      parity_en = 1'($urandom);
      parity_odd = 1'($urandom);
`endif
      refresh();
      step();
    end
    tx_en = 1'b1;
    run(300);
    pin("drain_fifo", fq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
